dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data_memory port between the CPU load/store path and a DMA/host loader port.
//  Fixed CPU priority with a DMA starvation guard.
//  Sequences synchronous-read accesses and raises cpu_stall so the single-cycle core holds its PC until its access completes.
//  Sits between cpu_16bit's mem_address/mem_write_data/mem_read/mem_write and data_memory.
// PARAMETERS
//  ADDR_W        16  address width, all ports
//  DATA_W        16  data width, all ports
//  STARVE_LIMIT  3   consecutive DMA losses before DMA is forced to win; range 1..15
// PORTS
//  clk          in   1       single clock, rising edge
//  pc_reset_n   in   1       asynchronous, active-low reset
//  cpu_req      in   1       CPU access request, held until cpu_ack
//  cpu_we       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_ack      out  1       CPU access complete (1-cycle pulse)
//  cpu_rdata    out  DATA_W  CPU read data, valid with cpu_ack, held afterwards
//  cpu_stall    out  1       = cpu_req & ~cpu_ack
//  dma_req      in   1       DMA request, held until dma_ack
//  dma_we       in   1       1 = write, 0 = read
//  dma_addr     in   ADDR_W  DMA address
//  dma_wdata    in   DATA_W  DMA write data
//  dma_ack      out  1       DMA access complete (1-cycle pulse)
//  dma_rdata    out  DATA_W  DMA read data, valid with dma_ack, held afterwards
//  mem_address     out  ADDR_W  to data_memory
//  mem_write_data  out  DATA_W  to data_memory
//  mem_read        out  1       to data_memory
//  mem_write       out  1       to data_memory
//  read_data       in   DATA_W  from data_memory; valid the cycle after mem_read issue
// BEHAVIOUR
//  FSM states:
//   - IDLE: bus free; arbitration happens here.
//   - CPU_RD, DMA_RD: read data phase.
//  IDLE winner (combinational):
//   - DMA if dma_req & starve_cnt==STARVE_LIMIT;
//   - else CPU if cpu_req;
//   - else DMA if dma_req;
//   - else none.
//  Winner drives mem_address/mem_write_data; mem_write=we, mem_read=~we.
//   - Write: ack in the same cycle; stay IDLE.
//   - Read: next state X_RD.
//  X_RD: no memory strobes; owner ack=1; owner rdata=read_data (combinational); read_data captured into owner's hold register; next state IDLE.
//   - Reads take 2 cycles; the next issue is no earlier than the cycle after X_RD.
//  Back-to-back writes: one per cycle.
//  No winner: mem_read=mem_write=0; mem_address and mem_write_data = 0.
//  starve_cnt (4 bit, saturating at STARVE_LIMIT):
//   - +1 in each IDLE cycle where dma_req=1 and CPU wins;
//   - cleared when DMA wins or dma_req=0.
//  Requesters keep req/we/addr/wdata stable until ack. Dropping req before ack is illegal; behaviour is undefined except under reset. req held high after ack means a new request.
//  Both idle: all strobes 0, state stays IDLE.
//  Reset (async, any state, including mid-read):
//   - state=IDLE, starve_cnt=0, hold registers=0;
//   - cpu_ack=dma_ack=0, mem_read=mem_write=0, rdata outputs=0 while pc_reset_n=0;
//   - an in-flight read is dropped with no ack;
//   - first arbitration happens in the first cycle after release.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_cpu_grants, stat_dma_grants and stat_conflicts (16 bit each, wrap at 0xFFFF->0, reset 0).
//   - stat_cpu_grants and stat_dma_grants +1 per access issued for that port.
//   - stat_conflicts +1 per IDLE cycle where cpu_req & dma_req.
//  ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 CPU write 0x0010<=0xBEEF, DMA idle -> same cycle: mem_write=1, mem_address=0x0010, cpu_ack=1, cpu_stall=0.
//  2 CPU read 0x0010 -> issue cycle: mem_read=1, cpu_stall=1; next cycle: cpu_ack=1, cpu_rdata=0xBEEF; cpu_rdata still 0xBEEF 3 cycles later.
//  3 CPU read 0x0020 and DMA read 0x0030 requested same cycle -> CPU issues at t0, CPU acks at t1, DMA issues at t2, DMA acks at t3.
//  4 CPU writes every cycle, DMA read pending -> CPU wins 3 IDLE cycles; DMA wins the 4th; starve_cnt returns to 0.
//  5 pc_reset_n=0 during CPU_RD -> cpu_ack=0 and strobes=0 immediately; after release with cpu_req=0, no ack ever appears.
//  6 ARB_STATS_EN defined, run test 3 -> stat_cpu_grants=1, stat_dma_grants=1, stat_conflicts=1.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (CPU and DMA) and data_memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] read_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_address, mem_write_data, mem_read, mem_write,
    input  read_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_address, mem_write_data, mem_read, mem_write,
    output read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data_memory port between the CPU and a DMA loader:
// CPU priority, starvation guard for DMA. Define ARB_STATS_EN to add grant/conflict counters.
module dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        pc_reset_n,
  dmem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] stat_cpu_grants,
  output logic [15:0] stat_dma_grants,
  output logic [15:0] stat_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_e;
  typedef enum logic [1:0] {WIN_NONE, WIN_CPU, WIN_DMA} winner_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0] dma_hold_q, dma_hold_d;
  winner_e           winner;

  // Arbitration only while the bus is free; reset suppresses any grant.
  always_comb begin
    winner = WIN_NONE;
    if (state_q == IDLE && pc_reset_n) begin
      if (bus.dma_req && starve_cnt_q == STARVE_MAX) winner = WIN_DMA;
      else if (bus.cpu_req)                          winner = WIN_CPU;
      else if (bus.dma_req)                          winner = WIN_DMA;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.cpu_ack        = 1'b0;
    bus.dma_ack        = 1'b0;
    bus.cpu_rdata      = cpu_hold_q;
    bus.dma_rdata      = dma_hold_q;

    unique case (winner)
      WIN_CPU: begin
        bus.mem_address    = bus.cpu_addr;
        bus.mem_write_data = bus.cpu_wdata;
        bus.mem_write      = bus.cpu_we;
        bus.mem_read       = ~bus.cpu_we;
        bus.cpu_ack        = bus.cpu_we;
      end
      WIN_DMA: begin
        bus.mem_address    = bus.dma_addr;
        bus.mem_write_data = bus.dma_wdata;
        bus.mem_write      = bus.dma_we;
        bus.mem_read       = ~bus.dma_we;
        bus.dma_ack        = bus.dma_we;
      end
      default: ;
    endcase

    // Read data phase: memory output goes straight to the owner alongside the ack.
    if (state_q == CPU_RD) begin
      bus.cpu_ack   = 1'b1;
      bus.cpu_rdata = bus.read_data;
    end
    if (state_q == DMA_RD) begin
      bus.dma_ack   = 1'b1;
      bus.dma_rdata = bus.read_data;
    end

    bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    cpu_hold_d   = cpu_hold_q;
    dma_hold_d   = dma_hold_q;

    unique case (state_q)
      IDLE: begin
        if (winner == WIN_CPU && !bus.cpu_we) state_d = CPU_RD;
        if (winner == WIN_DMA && !bus.dma_we) state_d = DMA_RD;
      end
      CPU_RD: begin
        cpu_hold_d = bus.read_data;
        state_d    = IDLE;
      end
      DMA_RD: begin
        dma_hold_d = bus.read_data;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Losses are counted only in IDLE; the count is kept across the CPU's read phase.
    if (!bus.dma_req || winner == WIN_DMA) begin
      starve_cnt_d = 4'd0;
    end else if (winner == WIN_CPU && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      // NOTE: the read-data hold registers are plain flops, so they are reset to give defined rdata.
      cpu_hold_q   <= '0;
      dma_hold_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_hold_q   <= cpu_hold_d;
      dma_hold_q   <= dma_hold_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stat_cpu_q, stat_cpu_d;
  logic [15:0] stat_dma_q, stat_dma_d;
  logic [15:0] stat_conf_q, stat_conf_d;

  // Counters wrap naturally at 16 bits.
  always_comb begin
    stat_cpu_d  = stat_cpu_q;
    stat_dma_d  = stat_dma_q;
    stat_conf_d = stat_conf_q;
    if (winner == WIN_CPU) stat_cpu_d = stat_cpu_q + 16'd1;
    if (winner == WIN_DMA) stat_dma_d = stat_dma_q + 16'd1;
    if (state_q == IDLE && bus.cpu_req && bus.dma_req) stat_conf_d = stat_conf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      stat_cpu_q  <= 16'd0;
      stat_dma_q  <= 16'd0;
      stat_conf_q <= 16'd0;
    end else begin
      stat_cpu_q  <= stat_cpu_d;
      stat_dma_q  <= stat_dma_d;
      stat_conf_q <= stat_conf_d;
    end
  end

  assign stat_cpu_grants = stat_cpu_q;
  assign stat_dma_grants = stat_dma_q;
  assign stat_conflicts  = stat_conf_q;
`endif

endmodule
